// File: rtl/header_pkg.sv
// header_pkg: shared phase indices, FSM state encoding and default widths for the header sequencer.
package header_pkg;
  localparam int PH_FRAME     = 0;
  localparam int PH_MATRIX    = 1;
  localparam int PH_PIC       = 2;
  localparam int PH_SLICE_TBL = 3;
  localparam int PH_SLICE_HDR = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_TMO_W    = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_CAPT, ST_FIN} state_e;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-phase cycle counter with a programmable limit strobe.
// Ports: clk_i/rst_n_i clock and sync active-low reset; clr_i zeroes the count;
// en_i advances it; limit_i cycle limit (0 = disabled); expire_o high on the last allowed cycle.
module phase_timer #(
  parameter int TMO_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [TMO_W-1:0] limit_i,
  output logic             expire_o
);
  logic [TMO_W-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + (TMO_W)'(1);
  end
  // Expiring at limit-1 keeps the run window exactly limit cycles wide.
  assign expire_o = en_i && (limit_i != '0) && (cnt_q == limit_i - (TMO_W)'(1));
endmodule

// File: rtl/header_phase_sequencer.sv
// header_phase_sequencer: runs the enabled header phases in order and records per-phase byte offsets/sizes.
// Ports: clock_i/reset_n_i clock and sync active-low reset; start_i/abort_i sequence control;
// phase_enable_i/phase_max_cycles_i/phase_done_i per-phase config and handshake;
// set_bit_total_byte_size_i running packer byte count; phase_run_o one-hot run enable;
// phase_start_o/phase_size_o captured offsets and sizes; phase_timeout_o sticky limit flags;
// busy_o sequence in progress; done_o completion pulse.
module header_phase_sequencer
  import header_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TMO_W      = DEF_TMO_W
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [NUM_PHASES-1:0]        phase_enable_i,
  input  logic [NUM_PHASES*TMO_W-1:0]  phase_max_cycles_i,
  input  logic [NUM_PHASES-1:0]        phase_done_i,
  input  logic [DATA_W-1:0]            set_bit_total_byte_size_i,
  output logic [NUM_PHASES-1:0]        phase_run_o,
  output logic [NUM_PHASES*DATA_W-1:0] phase_start_o,
  output logic [NUM_PHASES*DATA_W-1:0] phase_size_o,
  output logic [NUM_PHASES-1:0]        phase_timeout_o,
  output logic                         busy_o,
  output logic                         done_o
);
  localparam int IW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  state_e                  state_q;
  logic [IW-1:0]           cur_q;
  logic [NUM_PHASES-1:0]   run_q;
  logic [NUM_PHASES-1:0]   tmo_q;
  logic                    busy_q;
  logic                    done_q;
  logic [DATA_W-1:0]       start_q [NUM_PHASES];
  logic [DATA_W-1:0]       size_q  [NUM_PHASES];
  logic [TMO_W-1:0]        lim_a   [NUM_PHASES];
  logic [IW:0]             from;
  logic                    nxt_ok;
  logic [IW-1:0]           nxt;
  logic [NUM_PHASES-1:0]   nxt_oh;
  logic                    expire;
  for (genvar g = 0; g < NUM_PHASES; g++) begin : g_io
    assign lim_a[g] = phase_max_cycles_i[g*TMO_W +: TMO_W];
    assign phase_start_o[g*DATA_W +: DATA_W] = start_q[g];
    assign phase_size_o[g*DATA_W +: DATA_W]  = size_q[g];
  end
  // Next enabled phase: lowest one from 0 when idle, otherwise strictly after cur.
  always_comb begin
    from   = (state_q == ST_IDLE) ? '0 : {1'b0, cur_q} + (IW+1)'(1);
    nxt_ok = 1'b0;
    nxt    = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (phase_enable_i[i] && ((IW+1)'(i) >= from)) begin
        nxt_ok = 1'b1;
        nxt    = (IW)'(i);
      end
    end
    nxt_oh = (NUM_PHASES)'(1) << nxt;
  end
  phase_timer #(.TMO_W(TMO_W)) u_timer (
    .clk_i    (clock_i),
    .rst_n_i  (reset_n_i),
    .clr_i    (state_q != ST_RUN),
    .en_i     (state_q == ST_RUN),
    .limit_i  (lim_a[cur_q]),
    .expire_o (expire)
  );
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      run_q   <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int j = 0; j < NUM_PHASES; j++) begin
        start_q[j] <= '0;
        size_q[j]  <= '0;
      end
    end else if (abort_i && state_q != ST_IDLE) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i && !abort_i) begin
          busy_q  <= 1'b1;
          tmo_q   <= '0;
          cur_q   <= nxt;
          run_q   <= nxt_ok ? nxt_oh : '0;
          state_q <= nxt_ok ? ST_RUN : ST_FIN;
          done_q  <= !nxt_ok;
          // Leading skipped phases inherit the base offset of the first executed one.
          for (int j = 0; j < NUM_PHASES; j++) begin
            size_q[j]  <= '0;
            start_q[j] <= (!nxt_ok || (IW)'(j) <= nxt) ? set_bit_total_byte_size_i : '0;
          end
        end
        ST_RUN: if (phase_done_i[cur_q] || expire) begin
          if (!phase_done_i[cur_q]) tmo_q[cur_q] <= 1'b1;
          run_q   <= '0;
          state_q <= ST_CAPT;
        end
        ST_CAPT: begin
          size_q[cur_q] <= set_bit_total_byte_size_i - start_q[cur_q];
          // Skipped phases between cur and the next executed one share its start offset.
          for (int j = 0; j < NUM_PHASES; j++) begin
            if ((IW)'(j) > cur_q && (!nxt_ok || (IW)'(j) <= nxt)) start_q[j] <= set_bit_total_byte_size_i;
          end
          cur_q   <= nxt;
          run_q   <= nxt_ok ? nxt_oh : '0;
          state_q <= nxt_ok ? ST_RUN : ST_FIN;
          done_q  <= !nxt_ok;
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign phase_run_o     = run_q;
  assign phase_timeout_o = tmo_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
endmodule

// File: doc/header_phase_sequencer.md
Name: header_phase_sequencer

Overview:
Parametrised successor to the fixed-timing header sequencer in the ProRes encoder.
- Runs NUM_PHASES header-writer phases in order: frame header, matrix, picture header, slice size table, slice header.
- Each phase ends on a per-phase done handshake or on a programmable cycle limit; fixed counter compares are not used.
- After each phase it captures the running byte count and publishes per-phase start offsets and sizes to the bitstream packer and the size back-patch logic.

Parameters:
NUM_PHASES, 5, number of sequenced phases (>=1)
DATA_W, 32, width of byte counts and offsets
TMO_W, 16, width of per-phase cycle limit and timer

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a sequence when idle
abort  in  1  forces return to idle
phase_enable  in  NUM_PHASES  bit i=0 skips phase i
phase_max_cycles  in  NUM_PHASES*TMO_W  per-phase cycle limit, packed; 0 = no limit
phase_done  in  NUM_PHASES  per-phase completion pulse from sub-block i
set_bit_total_byte_size  in  DATA_W  running total bytes written by bit packer
phase_run  out  NUM_PHASES  one-hot run enable (active-high; replaces per-block *_reset_n)
phase_start  out  NUM_PHASES*DATA_W  byte count at entry to phase i
phase_size  out  NUM_PHASES*DATA_W  bytes produced by phase i
phase_timeout  out  NUM_PHASES  sticky: phase i ended on its cycle limit
busy  out  1  high from accepted start until done/abort
done  out  1  one-cycle pulse at sequence completion

Behaviour:
- Reset is synchronous (reset_n low at a clock edge). All outputs go to 0 and the FSM goes to IDLE. Reset mid-sequence has the same effect: phase_run drops on the next edge and captured values are cleared.
- FSM states: IDLE, RUN, CAPT, FIN.
- IDLE:
  - On start: latch base = set_bit_total_byte_size, clear phase_timeout, phase_start, phase_size.
  - Set cur = lowest enabled phase and enter RUN.
  - If no phase is enabled, go directly to FIN.
  - busy goes high the cycle after start.
- RUN:
  - phase_run[cur]=1; all other bits are 0.
  - Timer starts at 0 on entry and increments each cycle.
  - Exit to CAPT when phase_done[cur]=1, or when phase_max_cycles[cur]!=0 and timer==phase_max_cycles[cur]-1. In the limit case, set phase_timeout[cur].
  - If done and the limit coincide in the same cycle, done wins and phase_timeout is not set.
  - phase_done bits other than cur are ignored.
  - Minimum phase_run width is 1 cycle.
- CAPT: exactly one cycle with phase_run all 0. This allows the packer's byte count to settle.
  - end = set_bit_total_byte_size sampled in this cycle.
  - phase_size[cur] = end - phase_start[cur], modulo 2^DATA_W (wrap permitted, no saturation).
  - Advance to the next enabled phase j > cur: phase_start[j] = end, then RUN.
  - If no enabled phase remains, go to FIN.
- Skipped phase k: phase_start[k] = start value of the next executed phase (or the final end byte count); phase_size[k]=0; phase_run[k] never asserts.
- The first enabled phase has phase_start = base.
- FIN: done=1 for one cycle, busy=0 on the next cycle, return to IDLE. Captured outputs hold until the next accepted start.
- start while busy: ignored.
- abort (any state except IDLE):
  - Next cycle: phase_run=0, busy=0, state IDLE, no done pulse.
  - Captured values are kept; the current phase's size is not written.
  - abort and start in the same cycle in IDLE: abort wins and start is ignored.
- Back-patch offsets are derived by the consumer, not here: picture size at phase_start[2]+1, y/cb sizes at phase_start[4]+2 and +4.

Decomposition:
- Shared package (header_pkg): phase index constants PH_FRAME=0, PH_MATRIX=1, PH_PIC=2, PH_SLICE_TBL=3, PH_SLICE_HDR=4; FSM state encoding; default TMO_W/DATA_W.
- One sub-module: phase_timer. It provides a TMO_W counter with clear, enable and a limit compare, and outputs an expire strobe (0 = disabled).

Test Plan:
- All enabled, limits 0; done pulses after 0x20, 0x90, 0x10, 3, 0x10 cycles; byte count 0→0x94→0x194→0x1A4→0x1B0→0x1C8 → starts 0,0x94,0x194,0x1A4,0x1B0; sizes 0x94,0x100,0x10,0xC,0x18; done pulse one cycle after last CAPT.
- phase_max_cycles[3]=4, no phase_done[3] → phase_run[3] high exactly 4 cycles, phase_timeout=5'b01000, sequence completes.
- phase_enable=5'b10101 → phase_run never asserts for phases 1,3; size[1]=size[3]=0; start[1]=start[2], start[3]=start[4].
- abort during phase 2 RUN → phase_run 0 and busy 0 next cycle, no done, size[2] stays 0; new start runs a full sequence normally.
- reset_n low for 1 cycle during phase 1 → all outputs 0 on next edge; a start pulse during busy is ignored (no restart, timer continues).
- base=0xFFFFFFF0, end of phase 0=0x00000010 → size[0]=0x20 (wrap).
